// File: rtl/ysyx_rf_pkg.sv
// ysyx_rf_pkg: shared constants and types for the register-file writeback arbiter.
//   XLEN    - register data width
//   REG_AW  - register address width
//   NREG    - number of architectural registers
//   prio_e  - which writeback source wins when both request in the same cycle
//   wb_req_t - one writeback request (destination register + data)
package ysyx_rf_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 2 ** REG_AW;

  typedef enum logic {
    PRIO_LSU = 1'b0,
    PRIO_EXU = 1'b1
  } prio_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_rf_scoreboard.sv
// ysyx_rf_scoreboard: one busy bit per architectural register.
//   clk, rst_n     - clock, synchronous active-low reset
//   flush          - clears every busy bit
//   set_en, set_rd - mark set_rd busy (an instruction was dispatched to it)
//   clr_en, clr_rd - mark clr_rd free (its writeback was accepted)
//   rs1, rs2, rd   - operands/destination of the instruction trying to issue
//   hazard         - any of rs1/rs2/rd is still waiting for a writeback
module ysyx_rf_scoreboard
  import ysyx_rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_rd,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  output logic              hazard
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Clear is applied before set so that a register dispatched in the same
  // cycle its older writeback retires stays busy for the new producer.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Checks the registered state only: a writeback retiring this cycle is
  // not forwarded, so the dependent instruction issues one cycle later.
  assign hazard = busy[rs1] | busy[rs2] | busy[rd];

endmodule

// File: rtl/ysyx_rf_wb_arbiter.sv
// ysyx_rf_wb_arbiter: owns the single register-file write port.
//   clk, rst_n                  - clock, synchronous active-low reset
//   exu_wb_valid/ready/rd/data  - EXU writeback handshake
//   lsu_wb_valid/ready/rd/data  - LSU writeback handshake
//   issue_valid/ready           - dispatch handshake, ready low on RAW/WAW hazard
//   issue_rs1/rs2/rd            - registers of the dispatching instruction
//   flush                       - clears scoreboard and arbitration history
//   rf_wr_en/waddr/wdata        - registered register-file write port
// LSU normally wins a collision; after STARVE_LIMIT (1..15) consecutive EXU
// losses the EXU is owed one win, and priority returns to LSU once it gets it.
module ysyx_rf_wb_arbiter
  import ysyx_rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu_wb_valid,
  output logic              exu_wb_ready,
  input  logic [REG_AW-1:0] exu_wb_rd,
  input  logic [XLEN-1:0]   exu_wb_data,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              flush,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

  prio_e      prio;
  logic [3:0] starve_cnt;
  logic       exu_fire;
  logic       lsu_fire;
  logic       wb_fire;
  wb_req_t    wb_req;
  logic       hazard;
  logic       issue_fire;

  // A source is ready whenever it would win: always if the other source is
  // idle, otherwise only when it holds priority. Both may be high when idle.
  assign exu_wb_ready = rst_n & (!lsu_wb_valid | (prio == PRIO_EXU));
  assign lsu_wb_ready = rst_n & (!exu_wb_valid | (prio == PRIO_LSU));

  assign exu_fire = exu_wb_valid & exu_wb_ready;
  assign lsu_fire = lsu_wb_valid & lsu_wb_ready;
  assign wb_fire  = exu_fire | lsu_fire;

  // At most one handshake completes per cycle, so a simple select suffices.
  always_comb begin
    if (lsu_fire) begin
      wb_req.rd   = lsu_wb_rd;
      wb_req.data = lsu_wb_data;
    end else begin
      wb_req.rd   = exu_wb_rd;
      wb_req.data = exu_wb_data;
    end
  end

  // Priority FSM and starvation counter. With exu_wb_valid high and no EXU
  // handshake, the LSU necessarily won the collision.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      prio       <= PRIO_LSU;
      starve_cnt <= 4'd0;
    end else if (exu_fire) begin
      prio       <= PRIO_LSU;
      starve_cnt <= 4'd0;
    end else if (!exu_wb_valid) begin
      starve_cnt <= 4'd0;
    end else if (lsu_fire) begin
      if (starve_cnt == STARVE_MAX) begin
        prio <= PRIO_EXU;
      end else begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Registered write port; x0 writebacks are accepted but never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wr_en <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wr_en <= wb_fire && (wb_req.rd != '0);
      if (wb_fire && (wb_req.rd != '0)) begin
        rf_waddr <= wb_req.rd;
        rf_wdata <= wb_req.data;
      end
    end
  end

  assign issue_ready = rst_n & !hazard;
  assign issue_fire  = issue_valid & issue_ready;

  ysyx_rf_scoreboard u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .set_en (issue_fire),
    .set_rd (issue_rd),
    .clr_en (wb_fire),
    .clr_rd (wb_req.rd),
    .rs1    (issue_rs1),
    .rs2    (issue_rs2),
    .rd     (issue_rd),
    .hazard (hazard)
  );

endmodule

// File: tb/tb_ysyx_rf_wb_arbiter.sv
// tb_ysyx_rf_wb_arbiter: directed stimulus with a behavioural reference model
// and literal spot checks for ysyx_rf_wb_arbiter.
module tb_ysyx_rf_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_wb_valid, exu_wb_ready;
  logic [4:0]  exu_wb_rd;
  logic [31:0] exu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        flush;
  logic        rf_wr_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exu_wb_valid (exu_wb_valid),
    .exu_wb_ready (exu_wb_ready),
    .exu_wb_rd    (exu_wb_rd),
    .exu_wb_data  (exu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rs1    (issue_rs1),
    .issue_rs2    (issue_rs2),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .rf_wr_en     (rf_wr_en),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owed: the EXU has lost LIMIT collisions in a row and must win the next one.
  bit          m_busy [32];
  bit          m_owed;
  int          m_losses;
  logic        m_wr_en;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          started = 1'b0;

  function automatic bit m_hazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return m_busy[a] | m_busy[b] | m_busy[c];
  endfunction

  always @(posedge clk) begin
    bit exu_win, lsu_win, iss_go;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    started = 1'b1;
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_owed   = 1'b0;
      m_losses = 0;
      m_wr_en  = 1'b0;
      m_waddr  = '0;
      m_wdata  = '0;
    end else begin
      exu_win = exu_wb_valid && (!lsu_wb_valid || m_owed);
      lsu_win = lsu_wb_valid && !exu_win;
      iss_go  = issue_valid && !m_hazard(issue_rs1, issue_rs2, issue_rd);
      wrd     = exu_win ? exu_wb_rd : lsu_wb_rd;
      wdat    = exu_win ? exu_wb_data : lsu_wb_data;
      m_wr_en = (exu_win || lsu_win) && (wrd != 0);
      if (m_wr_en) begin
        m_waddr = wrd;
        m_wdata = wdat;
      end
      if (flush) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else begin
        if (exu_win || lsu_win) m_busy[wrd] = 1'b0;
        if (iss_go && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      end
      if (flush || exu_win) begin
        m_owed   = 1'b0;
        m_losses = 0;
      end else if (!exu_wb_valid) begin
        m_losses = 0;
      end else begin
        m_losses++;
        if (m_losses >= LIMIT) m_owed = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk1("exu_ready", exu_wb_ready, rst_n && (!lsu_wb_valid || m_owed));
      chk1("lsu_ready", lsu_wb_ready, rst_n && (!exu_wb_valid || !m_owed));
      chk1("issue_ready", issue_ready, rst_n && !m_hazard(issue_rs1, issue_rs2, issue_rd));
      chk1("rf_wr_en", rf_wr_en, m_wr_en);
      chk32("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk32("rf_wdata", rf_wdata, m_wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    exu_wb_valid = 0; exu_wb_rd = 0; exu_wb_data = 0;
    lsu_wb_valid = 0; lsu_wb_rd = 0; lsu_wb_data = 0;
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    flush = 0;
  endtask

  task automatic both(input logic [31:0] tag);
    exu_wb_valid = 1; exu_wb_rd = 5'd1; exu_wb_data = 32'h1000 + tag;
    lsu_wb_valid = 1; lsu_wb_rd = 5'd2; lsu_wb_data = 32'h2000 + tag;
  endtask

  initial begin
    idle();
    rst_n = 0;
    cyc(); cyc();
    smp();
    chk1("rst_exu_ready", exu_wb_ready, 1'b0);
    chk1("rst_lsu_ready", lsu_wb_ready, 1'b0);
    chk1("rst_issue_ready", issue_ready, 1'b0);
    chk1("rst_wr_en", rf_wr_en, 1'b0);
    chk32("rst_waddr", 32'(rf_waddr), 32'd0);
    chk32("rst_wdata", rf_wdata, 32'd0);
    cyc();
    rst_n = 1;

    // lone EXU writeback
    exu_wb_valid = 1; exu_wb_rd = 5'd5; exu_wb_data = 32'hDEADBEEF;
    smp(); chk1("lone_exu_ready", exu_wb_ready, 1'b1);
    cyc(); idle();
    smp();
    chk1("lone_exu_wr_en", rf_wr_en, 1'b1);
    chk32("lone_exu_waddr", 32'(rf_waddr), 32'd5);
    chk32("lone_exu_wdata", rf_wdata, 32'hDEADBEEF);
    cyc();
    smp();
    chk1("idle_wr_en", rf_wr_en, 1'b0);
    chk32("idle_waddr_hold", 32'(rf_waddr), 32'd5);

    // x0 writeback and attempted x0 dispatch
    cyc();
    lsu_wb_valid = 1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'h1234;
    issue_valid = 1; issue_rd = 5'd0;
    smp(); chk1("x0_lsu_ready", lsu_wb_ready, 1'b1);
    cyc(); idle();
    smp();
    chk1("x0_wr_en", rf_wr_en, 1'b0);
    chk32("x0_wdata_hold", rf_wdata, 32'hDEADBEEF);
    chk1("x0_not_busy", issue_ready, 1'b1);

    // starvation: LSU, LSU, LSU, LSU, EXU, LSU
    for (int k = 0; k < 6; k++) begin
      cyc(); both(32'(k));
      smp();
      chk1("starve_lsu_ready", lsu_wb_ready, k != 4);
      chk1("starve_exu_ready", exu_wb_ready, k == 4);
    end
    cyc(); idle();

    // owed EXU win survives an idle cycle without flush
    for (int k = 0; k < 4; k++) begin
      cyc(); both(32'(16 + k));
    end
    cyc(); idle();
    cyc(); both(32'h30);
    smp();
    chk1("owed_exu_ready", exu_wb_ready, 1'b1);
    chk1("owed_lsu_ready", lsu_wb_ready, 1'b0);

    // flush clears the owed win; LSU writeback during flush still lands
    for (int k = 0; k < 4; k++) begin
      cyc(); both(32'(32 + k));
    end
    cyc(); idle();
    flush = 1; lsu_wb_valid = 1; lsu_wb_rd = 5'd11; lsu_wb_data = 32'hB0B0;
    cyc(); idle(); both(32'h40);
    smp();
    chk1("flush_prio_lsu", lsu_wb_ready, 1'b1);
    chk1("flush_prio_exu", exu_wb_ready, 1'b0);
    chk1("flush_wb_wr_en", rf_wr_en, 1'b1);
    chk32("flush_wb_waddr", 32'(rf_waddr), 32'd11);
    cyc(); idle();

    // RAW hazard on x7
    issue_valid = 1; issue_rd = 5'd7;
    smp(); chk1("iss7_ready", issue_ready, 1'b1);
    cyc();
    issue_rs1 = 5'd7; issue_rd = 5'd8;
    smp(); chk1("raw7_stall", issue_ready, 1'b0);
    cyc();
    issue_valid = 0;
    exu_wb_valid = 1; exu_wb_rd = 5'd7; exu_wb_data = 32'h77;
    smp();
    chk1("wb7_exu_ready", exu_wb_ready, 1'b1);
    chk1("wb7_no_bypass", issue_ready, 1'b0);
    cyc();
    exu_wb_valid = 0;
    smp();
    chk1("wb7_released", issue_ready, 1'b1);
    chk32("wb7_wdata", rf_wdata, 32'h77);

    // WAW hazard on x10
    cyc(); idle();
    issue_valid = 1; issue_rd = 5'd10;
    cyc();
    issue_rs1 = 5'd1; issue_rs2 = 5'd2;
    smp(); chk1("waw10_stall", issue_ready, 1'b0);

    // same-cycle set and clear on x9: set wins
    cyc(); idle();
    issue_valid = 1; issue_rd = 5'd9;
    lsu_wb_valid = 1; lsu_wb_rd = 5'd9; lsu_wb_data = 32'h99;
    smp();
    chk1("sc9_issue_ready", issue_ready, 1'b1);
    chk1("sc9_lsu_ready", lsu_wb_ready, 1'b1);
    cyc(); idle();
    issue_rs2 = 5'd9;
    smp(); chk1("sc9_busy", issue_ready, 1'b0);

    // flush with a same-cycle dispatch
    cyc(); idle();
    issue_valid = 1; issue_rd = 5'd3;
    cyc(); issue_rd = 5'd4;
    cyc(); issue_valid = 0; issue_rs1 = 5'd3; issue_rd = 5'd0;
    smp(); chk1("x3_busy", issue_ready, 1'b0);
    cyc();
    issue_valid = 1; issue_rs1 = 5'd0; issue_rd = 5'd6; flush = 1;
    cyc(); idle();
    issue_rs1 = 5'd3; issue_rs2 = 5'd4; issue_rd = 5'd6;
    smp(); chk1("flush_all_clear", issue_ready, 1'b1);
    cyc(); issue_rs1 = 5'd9; issue_rs2 = 5'd10; issue_rd = 5'd0;
    smp(); chk1("flush_9_10_clear", issue_ready, 1'b1);

    // reset during a pending handshake
    cyc(); idle();
    rst_n = 0;
    exu_wb_valid = 1; exu_wb_rd = 5'd12; exu_wb_data = 32'hCC;
    issue_valid = 1; issue_rd = 5'd13;
    smp();
    chk1("rstmid_exu_ready", exu_wb_ready, 1'b0);
    chk1("rstmid_issue_ready", issue_ready, 1'b0);
    cyc(); idle();
    smp();
    chk1("rstmid_wr_en", rf_wr_en, 1'b0);
    chk32("rstmid_waddr", 32'(rf_waddr), 32'd0);
    cyc();
    rst_n = 1;
    issue_rd = 5'd13;
    smp(); chk1("rstmid_x13_free", issue_ready, 1'b1);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
